mac_lane_acc: RTL and testbench

- Pipelined, multi-lane multiply-accumulate unit for the systolic/PE datapath.
- Each lane holds a stationary signed weight, multiplies a streamed activation, and accumulates over a vector delimited by in_last.
- Activations are selectable unsigned or signed at run time; overflow handling (wrap or saturate) is a build parameter.
- Results are registered with a valid pulse, and back-to-back vectors run with no bubble.

---
 rtl/mac_lane_acc.sv | 162 ++++++++++++++++
 tb/tb_mac_lane_acc.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_lane_acc.sv
// mac_lane_acc
// Multi-lane multiply-accumulate unit for the PE datapath. Every lane keeps a
// stationary signed weight, multiplies it by a streamed activation and sums
// the products over a vector whose final beat is flagged with i_in_last.
// A result appears two cycles after the final beat, with a one-cycle valid
// pulse. The next vector may start in the cycle right after a last beat.
//
// Ports:
//   i_clk         clock, all state on the rising edge
//   i_reset       synchronous active-high reset
//   i_load_w      latch i_w_in into the weight registers this cycle
//   i_w_in        signed weights, lane i at [i*bw +: bw]
//   i_in_valid    activation beat valid
//   i_in_last     final beat of a vector (only meaningful with i_in_valid)
//   i_act_signed  per-beat activation mode: 0 unsigned, 1 two's complement
//   i_a_in        activations, lane i at [i*bw +: bw]
//   o_out_valid   one-cycle pulse, result outputs are valid
//   o_out_psum    signed accumulated result, lane i at [i*psum_bw +: psum_bw]
//   o_out_ovf     per-lane sticky overflow for the completed vector
//   o_out_cnt     beats in the completed vector, saturating at all-ones
module mac_lane_acc #(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int lanes   = 4,
   parameter int sat     = 0,
   parameter int cnt_bw  = 8
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_load_w,
   input  logic [lanes*bw-1:0]        i_w_in,
   input  logic                       i_in_valid,
   input  logic                       i_in_last,
   input  logic                       i_act_signed,
   input  logic [lanes*bw-1:0]        i_a_in,
   output logic                       o_out_valid,
   output logic [lanes*psum_bw-1:0]   o_out_psum,
   output logic [lanes-1:0]           o_out_ovf,
   output logic [cnt_bw-1:0]          o_out_cnt
);

   // Width of the lane product: (bw+1) x (bw+1) signed operands.
   localparam int pw = 2*bw + 2;

   logic              r_v1;
   logic              r_last1;
   logic              r_first;
   logic [cnt_bw-1:0] r_cnt;
   logic              r_outValid;
   logic [cnt_bw-1:0] r_outCnt;
   logic [cnt_bw-1:0] w_newCnt;

   // The element count restarts at 1 on the first beat of a vector and
   // otherwise increments, sticking at all-ones instead of wrapping.
   always_comb begin
      w_newCnt = r_cnt;
      if (r_first)
         w_newCnt = cnt_bw'(1);
      else if (r_cnt != {cnt_bw{1'b1}})
         w_newCnt = r_cnt + cnt_bw'(1);
   end

   // Shared control pipeline. Stage 1 carries the beat's valid and last
   // flags alongside the products; stage 2 advances the counter and decides
   // whether this beat closes the vector. Clearing r_v1 on reset is what
   // discards an in-flight beat of an interrupted vector.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_v1       <= 1'b0;
         r_last1    <= 1'b0;
         r_first    <= 1'b1;
         r_cnt      <= '0;
         r_outValid <= 1'b0;
         r_outCnt   <= '0;
      end else begin
         r_v1       <= i_in_valid;
         r_last1    <= i_in_valid & i_in_last;
         r_outValid <= r_v1 & r_last1;
         if (r_v1) begin
            r_cnt   <= w_newCnt;
            r_first <= r_last1;
            if (r_last1)
               r_outCnt <= w_newCnt;
         end
      end
   end

   assign o_out_valid = r_outValid;
   assign o_out_cnt   = r_outCnt;

   for (genvar g = 0; g < lanes; g++) begin : gLane
      logic signed [bw-1:0]      r_w;
      logic signed [pw-1:0]      r_p;
      logic signed [psum_bw-1:0] r_acc;
      logic                      r_ovfAcc;
      logic signed [psum_bw-1:0] r_outPsum;
      logic                      r_outOvf;

      logic signed [bw:0]        w_aExt;
      logic signed [bw:0]        w_wExt;
      logic signed [pw-1:0]      w_prod;
      logic signed [psum_bw:0]   w_ext;
      logic signed [psum_bw:0]   w_base;
      logic signed [psum_bw:0]   w_sum;
      logic                      w_ovf;
      logic signed [psum_bw-1:0] w_newAcc;
      logic                      w_newOvf;

      // Activations gain one extra bit so that unsigned and signed beats
      // share a single signed multiplier. The sum is formed one bit wider
      // than the accumulator, so overflow shows up as disagreement between
      // its top two bits; saturation then picks the bound on the side of the
      // true sign bit.
      always_comb begin
         w_aExt   = i_act_signed ? {i_a_in[g*bw+bw-1], i_a_in[g*bw +: bw]}
                                 : {1'b0, i_a_in[g*bw +: bw]};
         w_wExt   = {r_w[bw-1], r_w};
         w_prod   = pw'(w_aExt) * pw'(w_wExt);
         w_ext    = (psum_bw+1)'(r_p);
         w_base   = r_first ? '0 : (psum_bw+1)'(r_acc);
         w_sum    = w_base + w_ext;
         w_ovf    = w_sum[psum_bw] ^ w_sum[psum_bw-1];
         w_newAcc = w_sum[psum_bw-1:0];
         if (w_ovf && (sat != 0))
            w_newAcc = w_sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                      : {1'b0, {(psum_bw-1){1'b1}}};
         w_newOvf = (r_first ? 1'b0 : r_ovfAcc) | w_ovf;
      end

      // Per-lane state. A weight loaded in the same cycle as a beat only
      // takes effect for the following beat, because the stage-1 product
      // reads r_w before the update lands. Accumulator and overflow flag hold
      // across bubbles since they only move when stage 1 held a valid beat.
      always_ff @(posedge i_clk) begin
         if (i_reset) begin
            r_w       <= '0;
            r_p       <= '0;
            r_acc     <= '0;
            r_ovfAcc  <= 1'b0;
            r_outPsum <= '0;
            r_outOvf  <= 1'b0;
         end else begin
            if (i_load_w)
               r_w <= i_w_in[g*bw +: bw];
            if (i_in_valid)
               r_p <= w_prod;
            if (r_v1) begin
               r_acc    <= w_newAcc;
               r_ovfAcc <= w_newOvf;
               if (r_last1) begin
                  r_outPsum <= w_newAcc;
                  r_outOvf  <= w_newOvf;
               end
            end
         end
      end

      assign o_out_psum[g*psum_bw +: psum_bw] = r_outPsum;
      assign o_out_ovf[g]                     = r_outOvf;
   end

endmodule

// File: tb/tb_mac_lane_acc.sv
// tb_mac_lane_acc
// Directed bench for mac_lane_acc. A default-sized instance covers the main
// behaviour; two extra instances with a 10-bit accumulator (saturating and
// wrapping) share the same stimulus for the overflow scenario.
module tb_mac_lane_acc;

   logic        clk;
   logic        reset;
   logic        loadW;
   logic [15:0] wIn;
   logic        inValid;
   logic        inLast;
   logic        actSigned;
   logic [15:0] aIn;

   logic        outValidMain;
   logic [63:0] outPsumMain;
   logic [3:0]  outOvfMain;
   logic [7:0]  outCntMain;

   logic        outValidSat;
   logic [39:0] outPsumSat;
   logic [3:0]  outOvfSat;
   logic [7:0]  outCntSat;

   logic        outValidWrap;
   logic [39:0] outPsumWrap;
   logic [3:0]  outOvfWrap;
   logic [7:0]  outCntWrap;

   int checks = 0;
   int errors = 0;

   mac_lane_acc #(.bw(4), .psum_bw(16), .lanes(4), .sat(0), .cnt_bw(8)) dutMain (
      .i_clk(clk), .i_reset(reset), .i_load_w(loadW), .i_w_in(wIn),
      .i_in_valid(inValid), .i_in_last(inLast), .i_act_signed(actSigned),
      .i_a_in(aIn), .o_out_valid(outValidMain), .o_out_psum(outPsumMain),
      .o_out_ovf(outOvfMain), .o_out_cnt(outCntMain)
   );

   mac_lane_acc #(.bw(4), .psum_bw(10), .lanes(4), .sat(1), .cnt_bw(8)) dutSat (
      .i_clk(clk), .i_reset(reset), .i_load_w(loadW), .i_w_in(wIn),
      .i_in_valid(inValid), .i_in_last(inLast), .i_act_signed(actSigned),
      .i_a_in(aIn), .o_out_valid(outValidSat), .o_out_psum(outPsumSat),
      .o_out_ovf(outOvfSat), .o_out_cnt(outCntSat)
   );

   mac_lane_acc #(.bw(4), .psum_bw(10), .lanes(4), .sat(0), .cnt_bw(8)) dutWrap (
      .i_clk(clk), .i_reset(reset), .i_load_w(loadW), .i_w_in(wIn),
      .i_in_valid(inValid), .i_in_last(inLast), .i_act_signed(actSigned),
      .i_a_in(aIn), .o_out_valid(outValidWrap), .o_out_psum(outPsumWrap),
      .o_out_ovf(outOvfWrap), .o_out_cnt(outCntWrap)
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, clock it in, and return 1 unit after the
   // edge so outputs are read away from the edge.
   task automatic applyStimulus(input logic rst, input logic lw, input logic [15:0] w,
                                input logic v, input logic l, input logic s,
                                input logic [15:0] a);
      reset     = rst;
      loadW     = lw;
      wIn       = w;
      inValid   = v;
      inLast    = l;
      actSigned = s;
      aIn       = a;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
   endtask

   // Reset behaviour: every output of the main instance is zero.
   task automatic test_reset();
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
      checks++;
      if (outValidMain !== 1'b0 || outPsumMain !== 64'h0 || outOvfMain !== 4'h0 || outCntMain !== 8'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs got valid=%b psum=%h ovf=%b cnt=%0d want all zero",
                  outValidMain, outPsumMain, outOvfMain, outCntMain);
      end
      idle();
   endtask

   // Unsigned single beat: w=-8, a=15 gives -120 per lane, two cycles later.
   task automatic test_unsigned();
      logic signed [15:0] got;
      applyStimulus(1'b0, 1'b1, {4{4'h8}}, 1'b0, 1'b0, 1'b0, 16'h0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, {4{4'hF}});
      checks++;
      if (outValidMain !== 1'b0) begin
         errors++;
         $display("[TB] FAIL unsigned_early_valid got %b want 0", outValidMain);
      end
      idle();
      checks++;
      if (outValidMain !== 1'b1) begin
         errors++;
         $display("[TB] FAIL unsigned_valid_t2 got %b want 1", outValidMain);
      end
      for (int i = 0; i < 4; i++) begin
         got = outPsumMain[i*16 +: 16];
         checks++;
         if (got !== -16'sd120) begin
            errors++;
            $display("[TB] FAIL unsigned_psum lane%0d got %0d want -120", i, got);
         end
      end
      checks++;
      if (outOvfMain !== 4'h0 || outCntMain !== 8'd1) begin
         errors++;
         $display("[TB] FAIL unsigned_ovf_cnt got ovf=%b cnt=%0d want ovf=0000 cnt=1", outOvfMain, outCntMain);
      end
      idle();
      checks++;
      if (outValidMain !== 1'b0 || outPsumMain[15:0] !== 16'hFF88) begin
         errors++;
         $display("[TB] FAIL unsigned_hold got valid=%b psum0=%h want valid=0 psum0=ff88",
                  outValidMain, outPsumMain[15:0]);
      end
   endtask

   // Signed mode with w=-8: a=F signed is -1 -> +8; unsigned again -> -120.
   // A mixed-lane beat then checks lanes stay independent.
   task automatic test_signed();
      logic signed [15:0] got;
      logic signed [15:0] want [4];
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, {4{4'hF}});
      idle();
      for (int i = 0; i < 4; i++) begin
         got = outPsumMain[i*16 +: 16];
         checks++;
         if (outValidMain !== 1'b1 || got !== 16'sd8) begin
            errors++;
            $display("[TB] FAIL signed_psum lane%0d got valid=%b psum=%0d want valid=1 psum=8", i, outValidMain, got);
         end
      end
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, {4{4'hF}});
      idle();
      got = outPsumMain[31:16];
      checks++;
      if (outValidMain !== 1'b1 || got !== -16'sd120) begin
         errors++;
         $display("[TB] FAIL signed_then_unsigned got valid=%b psum=%0d want valid=1 psum=-120", outValidMain, got);
      end
      // Lanes 3..0 activations F,1,7,8 signed: -1,1,7,-8 times -8.
      want[0] = 16'sd64;
      want[1] = -16'sd56;
      want[2] = -16'sd8;
      want[3] = 16'sd8;
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 16'hF178);
      idle();
      for (int i = 0; i < 4; i++) begin
         got = outPsumMain[i*16 +: 16];
         checks++;
         if (got !== want[i]) begin
            errors++;
            $display("[TB] FAIL signed_mixed_lane lane%0d got %0d want %0d", i, got, want[i]);
         end
      end
   endtask

   // w=3, beats 1,2,bubble,bubble,5(last): 24, cnt 3, one pulse at t+2.
   task automatic test_bubbles();
      int pulses;
      int pulseAt;
      logic signed [15:0] got;
      pulses  = 0;
      pulseAt = -1;
      applyStimulus(1'b0, 1'b1, {4{4'h3}}, 1'b0, 1'b0, 1'b0, 16'h0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, {4{4'h1}});
      if (outValidMain) begin pulses++; pulseAt = 0; end
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, {4{4'h2}});
      if (outValidMain) begin pulses++; pulseAt = 1; end
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, {4{4'h9}});
      if (outValidMain) begin pulses++; pulseAt = 2; end
      idle();
      if (outValidMain) begin pulses++; pulseAt = 3; end
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, {4{4'h5}});
      if (outValidMain) begin pulses++; pulseAt = 4; end
      for (int c = 5; c < 10; c++) begin
         idle();
         if (outValidMain) begin
            pulses++;
            pulseAt = c;
            got = outPsumMain[15:0];
            checks++;
            if (got !== 16'sd24 || outCntMain !== 8'd3 || outOvfMain !== 4'h0) begin
               errors++;
               $display("[TB] FAIL bubble_result got psum=%0d cnt=%0d ovf=%b want psum=24 cnt=3 ovf=0000",
                        got, outCntMain, outOvfMain);
            end
         end
      end
      checks++;
      if (pulses != 1 || pulseAt != 5) begin
         errors++;
         $display("[TB] FAIL bubble_pulse got pulses=%0d at=%0d want pulses=1 at=5", pulses, pulseAt);
      end
   endtask

   // Vector A (w=2, a=4,4) with weight swap to -1 on its last beat, then
   // vector B a=7 immediately: A=16, B=-7, results in consecutive cycles.
   task automatic test_back_to_back();
      logic signed [15:0] got;
      applyStimulus(1'b0, 1'b1, {4{4'h2}}, 1'b0, 1'b0, 1'b0, 16'h0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, {4{4'h4}});
      applyStimulus(1'b0, 1'b1, {4{4'hF}}, 1'b1, 1'b1, 1'b0, {4{4'h4}});
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, {4{4'h7}});
      got = outPsumMain[47:32];
      checks++;
      if (outValidMain !== 1'b1 || got !== 16'sd16 || outCntMain !== 8'd2) begin
         errors++;
         $display("[TB] FAIL b2b_vector_a got valid=%b psum=%0d cnt=%0d want valid=1 psum=16 cnt=2",
                  outValidMain, got, outCntMain);
      end
      idle();
      got = outPsumMain[63:48];
      checks++;
      if (outValidMain !== 1'b1 || got !== -16'sd7 || outCntMain !== 8'd1) begin
         errors++;
         $display("[TB] FAIL b2b_vector_b got valid=%b psum=%0d cnt=%0d want valid=1 psum=-7 cnt=1",
                  outValidMain, got, outCntMain);
      end
      idle();
      checks++;
      if (outValidMain !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_pulse_end got %b want 0", outValidMain);
      end
   endtask

   // w=7, five unsigned beats of 15: 525. Fits 16 bits; 10-bit instances
   // overflow and either clamp to 511 or wrap to -499.
   task automatic test_overflow();
      logic signed [15:0] gotMain;
      logic signed [9:0]  gotSat;
      logic signed [9:0]  gotWrap;
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
      applyStimulus(1'b0, 1'b1, {4{4'h7}}, 1'b0, 1'b0, 1'b0, 16'h0);
      for (int b = 0; b < 5; b++)
         applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, (b == 4), 1'b0, {4{4'hF}});
      idle();
      checks++;
      if (outValidMain !== 1'b1 || outValidSat !== 1'b1 || outValidWrap !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ovf_valid got main=%b sat=%b wrap=%b want 1 1 1", outValidMain, outValidSat, outValidWrap);
      end
      for (int i = 0; i < 4; i++) begin
         gotMain = outPsumMain[i*16 +: 16];
         gotSat  = outPsumSat[i*10 +: 10];
         gotWrap = outPsumWrap[i*10 +: 10];
         checks++;
         if (gotMain !== 16'sd525 || outOvfMain[i] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_main lane%0d got psum=%0d ovf=%b want psum=525 ovf=0", i, gotMain, outOvfMain[i]);
         end
         checks++;
         if (gotSat !== 10'sd511 || outOvfSat[i] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_sat lane%0d got psum=%0d ovf=%b want psum=511 ovf=1", i, gotSat, outOvfSat[i]);
         end
         checks++;
         if (gotWrap !== -10'sd499 || outOvfWrap[i] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_wrap lane%0d got psum=%0d ovf=%b want psum=-499 ovf=1", i, gotWrap, outOvfWrap[i]);
         end
      end
      checks++;
      if (outCntMain !== 8'd5 || outCntSat !== 8'd5) begin
         errors++;
         $display("[TB] FAIL ovf_cnt got main=%0d sat=%0d want 5 5", outCntMain, outCntSat);
      end
   endtask

   // Two beats of a three-beat vector, then reset (with the would-be last
   // beat presented during reset). Nothing may emerge from the aborted
   // vector; a fresh vector with w=5, a=1 gives 5, cnt 1.
   task automatic test_reset_mid_vector();
      int pulses;
      logic signed [15:0] got;
      pulses = 0;
      applyStimulus(1'b0, 1'b1, {4{4'h2}}, 1'b0, 1'b0, 1'b0, 16'h0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, {4{4'h3}});
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, {4{4'h3}});
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, {4{4'h3}});
      checks++;
      if (outValidMain !== 1'b0 || outPsumMain !== 64'h0 || outOvfMain !== 4'h0 || outCntMain !== 8'h0) begin
         errors++;
         $display("[TB] FAIL midreset_during got valid=%b psum=%h ovf=%b cnt=%0d want all zero",
                  outValidMain, outPsumMain, outOvfMain, outCntMain);
      end
      for (int c = 0; c < 3; c++) begin
         idle();
         if (outValidMain !== 1'b0 || outPsumMain !== 64'h0 || outCntMain !== 8'h0) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("[TB] FAIL midreset_after got %0d nonzero cycles want 0", pulses);
      end
      applyStimulus(1'b0, 1'b1, {4{4'h5}}, 1'b0, 1'b0, 1'b0, 16'h0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, {4{4'h1}});
      idle();
      got = outPsumMain[15:0];
      checks++;
      if (outValidMain !== 1'b1 || got !== 16'sd5 || outCntMain !== 8'd1 || outOvfMain !== 4'h0) begin
         errors++;
         $display("[TB] FAIL midreset_new got valid=%b psum=%0d cnt=%0d ovf=%b want valid=1 psum=5 cnt=1 ovf=0000",
                  outValidMain, got, outCntMain, outOvfMain);
      end
   endtask

   initial begin
      reset     = 1'b1;
      loadW     = 1'b0;
      wIn       = 16'h0;
      inValid   = 1'b0;
      inLast    = 1'b0;
      actSigned = 1'b0;
      aIn       = 16'h0;
      test_reset();
      test_unsigned();
      test_signed();
      test_bubbles();
      test_back_to_back();
      test_overflow();
      test_reset_mid_vector();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
